// File: rtl/ecc_syndrome_pipe.sv
// Two-stage valid/ready syndrome calculator for the multi-mode extended-Hamming path.
// Define ECC_SYN_ERR_CNT_EN to build the saturating single/double error counters.
module ecc_syndrome_pipe #(
  parameter  int MAX_CODEWORD_WIDTH = 32,
  parameter  int TAG_WIDTH          = 4,
  parameter  int ERR_CNT_WIDTH      = 16,
  localparam int PW                 = $clog2(MAX_CODEWORD_WIDTH) + 1,
  localparam int LW                 = PW - 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_CODEWORD_WIDTH-1:0] in_data,
  input  logic [1:0]                    in_mode,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PW-1:0]                 out_syndrome,
  output logic [1:0]                    out_status,
  output logic [LW-1:0]                 out_err_pos,
  output logic [TAG_WIDTH-1:0]          out_tag,
  input  logic                          cnt_clr,
  output logic [ERR_CNT_WIDTH-1:0]      cnt_single,
  output logic [ERR_CNT_WIDTH-1:0]      cnt_double
);

  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_SINGLE  = 2'b01,
    ST_DOUBLE  = 2'b10,
    ST_ILLEGAL = 2'b11
  } status_e;

  logic                          s1_valid_q, s1_valid_d;
  logic [MAX_CODEWORD_WIDTH-1:0] s1_data_q;
  logic [1:0]                    s1_mode_q;
  logic [TAG_WIDTH-1:0]          s1_tag_q;

  logic                          out_valid_q;
  logic [PW-1:0]                 syn_q, syn_d;
  status_e                       status_q, status_d;
  logic [LW-1:0]                 pos_q, pos_d;
  logic [TAG_WIDTH-1:0]          tag_q;

  logic                          s2_free;
  logic                          accept;
  logic [MAX_CODEWORD_WIDTH-1:0] in_masked;
  logic [LW-1:0]                 pos_syn;
  logic                          par;
  int                            n_act;

  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept)       s1_valid_d = 1'b1;
    else if (s2_free) s1_valid_d = 1'b0;
  end

  // Bits at or above the active width never reach the syndrome logic.
  always_comb begin
    n_act     = 0;
    in_masked = '0;
    case (in_mode)
      2'b00:   n_act = MAX_CODEWORD_WIDTH / 4;
      2'b01:   n_act = MAX_CODEWORD_WIDTH / 2;
      2'b10:   n_act = MAX_CODEWORD_WIDTH;
      default: n_act = 0;
    endcase
    for (int j = 0; j < MAX_CODEWORD_WIDTH; j++) begin
      in_masked[j] = in_data[j] && (j < n_act);
    end
  end

  // Position rows of H are the binary column indices, so the position syndrome
  // is the XOR of the indices of all set bits; bits above P-2 stay 0 naturally.
  always_comb begin
    pos_syn  = '0;
    par      = 1'b0;
    syn_d    = '0;
    status_d = ST_NONE;
    pos_d    = '0;
    for (int j = 0; j < MAX_CODEWORD_WIDTH; j++) begin
      if (s1_data_q[j]) begin
        pos_syn = pos_syn ^ LW'(j);
        par     = ~par;
      end
    end
    if (s1_mode_q == 2'b11) begin
      status_d = ST_ILLEGAL;
    end else begin
      syn_d = {par, pos_syn};
      if (par) begin
        status_d = ST_SINGLE;
        pos_d    = pos_syn;
      end else if (pos_syn != '0) begin
        status_d = ST_DOUBLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_mode_q   <= 2'b00;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      syn_q       <= '0;
      status_q    <= ST_NONE;
      pos_q       <= '0;
      tag_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_data_q <= in_masked;
        s1_mode_q <= in_mode;
        s1_tag_q  <= in_tag;
      end
      if (s2_free) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          syn_q    <= syn_d;
          status_q <= status_d;
          pos_q    <= pos_d;
          tag_q    <= s1_tag_q;
        end
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_syndrome = syn_q;
  assign out_status   = status_q;
  assign out_err_pos  = pos_q;
  assign out_tag      = tag_q;

`ifdef ECC_SYN_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] cnt_single_q, cnt_double_q;
  logic                     out_fire;

  assign out_fire = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else if (cnt_clr) begin
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else if (out_fire) begin
      if (status_q == ST_SINGLE && cnt_single_q != '1)
        cnt_single_q <= cnt_single_q + ERR_CNT_WIDTH'(1);
      if (status_q == ST_DOUBLE && cnt_double_q != '1)
        cnt_double_q <= cnt_double_q + ERR_CNT_WIDTH'(1);
    end
  end

  assign cnt_single = cnt_single_q;
  assign cnt_double = cnt_double_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_single     = '0;
  assign cnt_double     = '0;
`endif

endmodule

// File: tb/tb_ecc_syndrome_pipe.sv
// Randomized and directed bench for ecc_syndrome_pipe; a second instance with
// 2-bit counters shares the stimulus to exercise counter saturation.
module tb_ecc_syndrome_pipe;
  localparam int MAXW = 32;
`ifdef ECC_SYN_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_syndrome;
  logic [1:0]  out_status;
  logic [4:0]  out_err_pos;
  logic [3:0]  out_tag;
  logic        cnt_clr = 1'b0;
  logic [15:0] cnt_single, cnt_double;
  logic [1:0]  cnt2_single, cnt2_double;
  logic        unused_ir2, unused_ov2;
  logic [5:0]  unused_syn2;
  logic [1:0]  unused_st2;
  logic [4:0]  unused_pos2;
  logic [3:0]  unused_tag2;

  always #5 clk = ~clk;

  ecc_syndrome_pipe #(.MAX_CODEWORD_WIDTH(32), .TAG_WIDTH(4), .ERR_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_syndrome(out_syndrome), .out_status(out_status), .out_err_pos(out_err_pos),
    .out_tag(out_tag), .cnt_clr(cnt_clr), .cnt_single(cnt_single), .cnt_double(cnt_double));

  ecc_syndrome_pipe #(.MAX_CODEWORD_WIDTH(32), .TAG_WIDTH(4), .ERR_CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(unused_ir2), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag), .out_valid(unused_ov2), .out_ready(out_ready),
    .out_syndrome(unused_syn2), .out_status(unused_st2), .out_err_pos(unused_pos2),
    .out_tag(unused_tag2), .cnt_clr(cnt_clr), .cnt_single(cnt2_single), .cnt_double(cnt2_double));

  typedef struct packed {
    logic [5:0] syn;
    logic [1:0] st;
    logic [4:0] pos;
    logic [3:0] tag;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;
  int ms = 0, md = 0, ms2 = 0, md2 = 0;

  logic       obs_in_ready, obs_out_valid, obs_in_fire, obs_out_fire;
  logic [5:0] obs_syn;
  logic [1:0] obs_st;
  logic [4:0] obs_pos;
  logic [3:0] obs_tag;
  logic [15:0] obs_cs, obs_cd;
  logic [1:0]  obs_cs2, obs_cd2;

  // Reference: build each row of H for the selected code and take its parity with the word.
  function automatic exp_t model(input logic [31:0] d, input logic [1:0] m, input logic [3:0] t);
    exp_t e;
    int n, p;
    logic [4:0] rows;
    logic ov;
    e.tag = t; e.syn = '0; e.st = 2'b11; e.pos = '0;
    if (m != 2'b11) begin
      n = (MAXW / 4) << m;
      p = $clog2(n) + 1;
      rows = '0; ov = 1'b0;
      for (int j = 0; j < n; j++) begin
        ov = ov ^ d[j];
        for (int r = 0; r < p - 1; r++)
          if (((j >> r) & 1) == 1) rows[r] = rows[r] ^ d[j];
      end
      e.syn = {ov, rows};
      if (ov) begin e.st = 2'b01; e.pos = rows; end
      else if (rows != 0) e.st = 2'b10;
      else e.st = 2'b00;
    end
    return e;
  endfunction

  function automatic int bump(input int c, input int mx);
    return (c < mx) ? c + 1 : c;
  endfunction

  task automatic count_event(input logic [1:0] st, input logic clr);
    if (clr) begin
      ms = 0; md = 0; ms2 = 0; md2 = 0;
    end else begin
      if (st == 2'b01) begin ms = bump(ms, 65535); ms2 = bump(ms2, 3); end
      if (st == 2'b10) begin md = bump(md, 65535); md2 = bump(md2, 3); end
    end
  endtask

  task automatic drive_cycle(input logic v, input logic [31:0] d, input logic [1:0] m,
                             input logic [3:0] t, input logic ordy, input logic clr);
    @(negedge clk);
    in_valid = v; in_data = d; in_mode = m; in_tag = t; out_ready = ordy; cnt_clr = clr;
    #1;
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    obs_in_fire   = v && in_ready;
    obs_out_fire  = out_valid && ordy;
    obs_syn = out_syndrome; obs_st = out_status; obs_pos = out_err_pos; obs_tag = out_tag;
    obs_cs = cnt_single; obs_cd = cnt_double; obs_cs2 = cnt2_single; obs_cd2 = cnt2_double;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    n_tests++;
    if ({in_ready, out_valid, out_syndrome, out_status, out_err_pos, out_tag} !== {1'b1, 1'b0, 17'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got ir=%0b ov=%0b syn=%0h st=%0h pos=%0h tag=%0h expected ir=1 ov=0 rest 0",
               in_ready, out_valid, out_syndrome, out_status, out_err_pos, out_tag);
    end
    n_tests++;
    if ({cnt_single, cnt_double, cnt2_single, cnt2_double} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0h %0h %0h %0h expected 0", cnt_single, cnt_double, cnt2_single, cnt2_double);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    ms = 0; md = 0; ms2 = 0; md2 = 0;
  endtask

  task automatic test_directed();
    logic [31:0] dv [5];
    logic [1:0]  mv [5];
    logic [5:0]  sv [5];
    logic [1:0]  stv [5];
    logic [4:0]  pv [5];
    dv  = '{32'h0, 32'h0000_2000, 32'h0000_0028, 32'hFFFF_FF80, 32'hDEAD_BEEF};
    mv  = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b11};
    sv  = '{6'b000000, 6'b101101, 6'b000110, 6'b100111, 6'b000000};
    stv = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b11};
    pv  = '{5'd0, 5'd13, 5'd0, 5'd7, 5'd0};
    drive_cycle(1'b0, 32'h0, 2'b00, 4'h0, 1'b1, 1'b1);
    count_event(2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, dv[i], mv[i], 4'(i + 5), 1'b1, 1'b0);
      n_tests++;
      if (obs_in_ready !== 1'b1) begin
        n_fail++; $display("FAIL dir_in_ready[%0d]: got %0b expected 1", i, obs_in_ready);
      end
      drive_cycle(1'b0, 32'h0, 2'b00, 4'h0, 1'b1, 1'b0);
      n_tests++;
      if (obs_out_valid !== 1'b0) begin
        n_fail++; $display("FAIL dir_latency_early[%0d]: got out_valid %0b expected 0", i, obs_out_valid);
      end
      drive_cycle(1'b0, 32'h0, 2'b00, 4'h0, 1'b1, 1'b0);
      n_tests++;
      if ({obs_out_valid, obs_syn, obs_st, obs_pos, obs_tag} !== {1'b1, sv[i], stv[i], pv[i], 4'(i + 5)}) begin
        n_fail++;
        $display("FAIL dir_result[%0d]: got v=%0b syn=%b st=%b pos=%0d tag=%0d expected v=1 syn=%b st=%b pos=%0d tag=%0d",
                 i, obs_out_valid, obs_syn, obs_st, obs_pos, obs_tag, sv[i], stv[i], pv[i], i + 5);
      end
      count_event(stv[i], 1'b0);
      drive_cycle(1'b0, 32'h0, 2'b00, 4'h0, 1'b1, 1'b0);
      n_tests++;
      if ({obs_cs, obs_cd} !== {16'(CNT_EN ? ms : 0), 16'(CNT_EN ? md : 0)}) begin
        n_fail++;
        $display("FAIL dir_counters[%0d]: got s=%0d d=%0d expected s=%0d d=%0d",
                 i, obs_cs, obs_cd, CNT_EN ? ms : 0, CNT_EN ? md : 0);
      end
    end
  endtask

  task automatic test_backpressure();
    int next_tag = 1;
    int exp_tag  = 1;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(next_tag <= 3, 32'h0, 2'b10, 4'(next_tag), i >= 5, 1'b0);
      if (i >= 2 && i <= 4) begin
        n_tests++;
        if ({obs_in_ready, obs_out_valid, obs_tag} !== {1'b0, 1'b1, 4'd1}) begin
          n_fail++;
          $display("FAIL bp_full[%0d]: got ir=%0b ov=%0b tag=%0d expected ir=0 ov=1 tag=1",
                   i, obs_in_ready, obs_out_valid, obs_tag);
        end
      end
      if (obs_in_fire) next_tag++;
      if (obs_out_fire) begin
        n_tests++;
        if (obs_tag !== 4'(exp_tag) || i != 4 + exp_tag) begin
          n_fail++;
          $display("FAIL bp_order: got tag %0d at cycle %0d expected tag %0d at cycle %0d",
                   obs_tag, i, exp_tag, 4 + exp_tag);
        end
        exp_tag++;
      end
    end
    n_tests++;
    if (exp_tag != 4 || next_tag != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d emitted %0d accepted expected 3 3", exp_tag - 1, next_tag - 1);
    end
  endtask

  task automatic test_saturation();
    drive_cycle(1'b0, 32'h0, 2'b00, 4'h0, 1'b1, 1'b1);
    count_event(2'b00, 1'b1);
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 32'h0000_2000, 2'b10, 4'(i), 1'b1, 1'b0);
    repeat (3) drive_cycle(1'b0, 32'h0, 2'b00, 4'h0, 1'b1, 1'b0);
    n_tests++;
    if ({obs_cs2, obs_cs} !== {2'(CNT_EN ? 3 : 0), 16'(CNT_EN ? 5 : 0)}) begin
      n_fail++;
      $display("FAIL sat_single: got w2=%0d w16=%0d expected w2=%0d w16=%0d",
               obs_cs2, obs_cs, CNT_EN ? 3 : 0, CNT_EN ? 5 : 0);
    end
    drive_cycle(1'b1, 32'h0000_2000, 2'b10, 4'h6, 1'b1, 1'b0);
    drive_cycle(1'b0, 32'h0, 2'b00, 4'h0, 1'b1, 1'b0);
    drive_cycle(1'b0, 32'h0, 2'b00, 4'h0, 1'b1, 1'b1);
    n_tests++;
    if ({obs_out_fire, obs_st} !== 3'b101) begin
      n_fail++;
      $display("FAIL sat_clr_handshake: got fire=%0b st=%b expected fire=1 st=01", obs_out_fire, obs_st);
    end
    drive_cycle(1'b0, 32'h0, 2'b00, 4'h0, 1'b1, 1'b0);
    n_tests++;
    if ({obs_cs2, obs_cs} !== 18'h0) begin
      n_fail++;
      $display("FAIL sat_clr_priority: got w2=%0d w16=%0d expected 0 0", obs_cs2, obs_cs);
    end
    count_event(2'b00, 1'b1);
  endtask

  task automatic test_random();
    exp_t sb[$];
    exp_t e;
    logic v, ordy, clr;
    logic [31:0] d;
    logic [1:0] m;
    logic [3:0] t;
    int sz;
    for (int c = 0; c < 400; c++) begin
      v    = (c < 390) && ($urandom_range(0, 9) < 7);
      ordy = (c >= 390) || ($urandom_range(0, 9) < 6);
      clr  = (c < 390) && ($urandom_range(0, 19) == 0);
      d = $urandom(); m = 2'($urandom_range(0, 3)); t = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) d = 32'h1 << $urandom_range(0, 31);
      sz = sb.size();
      drive_cycle(v, d, m, t, ordy, clr);
      n_tests++;
      if (obs_in_ready !== ((sz < 2) || ordy)) begin
        n_fail++;
        $display("FAIL rnd_in_ready[%0d]: got %0b expected %0b (occupancy %0d)", c, obs_in_ready, (sz < 2) || ordy, sz);
      end
      n_tests++;
      if ({obs_cs, obs_cd, obs_cs2, obs_cd2} !==
          {16'(CNT_EN ? ms : 0), 16'(CNT_EN ? md : 0), 2'(CNT_EN ? ms2 : 0), 2'(CNT_EN ? md2 : 0)}) begin
        n_fail++;
        $display("FAIL rnd_counters[%0d]: got %0d %0d %0d %0d expected %0d %0d %0d %0d", c,
                 obs_cs, obs_cd, obs_cs2, obs_cd2, CNT_EN ? ms : 0, CNT_EN ? md : 0,
                 CNT_EN ? ms2 : 0, CNT_EN ? md2 : 0);
      end
      e = '0;
      if (obs_out_fire) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_spurious[%0d]: got output tag %0d expected none", c, obs_tag);
        end else begin
          e = sb.pop_front();
          if ({obs_syn, obs_st, obs_pos, obs_tag} !== e) begin
            n_fail++;
            $display("FAIL rnd_result[%0d]: got syn=%b st=%b pos=%0d tag=%0d expected syn=%b st=%b pos=%0d tag=%0d",
                     c, obs_syn, obs_st, obs_pos, obs_tag, e.syn, e.st, e.pos, e.tag);
          end
        end
      end
      count_event(obs_out_fire ? e.st : 2'b00, clr);
      if (obs_in_fire) sb.push_back(model(d, m, t));
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_drain: got %0d words left expected 0", sb.size());
    end
  endtask

  task automatic test_reset_midstream();
    drive_cycle(1'b1, 32'h0000_2000, 2'b10, 4'h1, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h0000_0028, 2'b10, 4'h2, 1'b0, 1'b0);
    drive_cycle(1'b0, 32'h0, 2'b00, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, in_ready, out_tag, out_status} !== {1'b0, 1'b1, 4'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL mid_reset: got ov=%0b ir=%0b tag=%0d st=%b expected ov=0 ir=1 tag=0 st=00",
               out_valid, in_ready, out_tag, out_status);
    end
    @(negedge clk) rst = 1'b1;
    count_event(2'b00, 1'b1);
    drive_cycle(1'b1, 32'h0000_2000, 2'b10, 4'h9, 1'b1, 1'b0);
    drive_cycle(1'b0, 32'h0, 2'b00, 4'h0, 1'b1, 1'b0);
    drive_cycle(1'b0, 32'h0, 2'b00, 4'h0, 1'b1, 1'b0);
    n_tests++;
    if ({obs_out_valid, obs_syn, obs_st, obs_pos, obs_tag, obs_cs} !==
        {1'b1, 6'b101101, 2'b01, 5'd13, 4'h9, 16'h0}) begin
      n_fail++;
      $display("FAIL post_reset_word: got v=%0b syn=%b st=%b pos=%0d tag=%0d cnt=%0d expected v=1 syn=101101 st=01 pos=13 tag=9 cnt=0",
               obs_out_valid, obs_syn, obs_st, obs_pos, obs_tag, obs_cs);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    repeat (3) drive_cycle(1'b0, 32'h0, 2'b00, 4'h0, 1'b1, 1'b0);
    test_saturation();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
